// File: rtl/dir_request_sequencer_if.sv
// dir_request_sequencer_if: request/issue bus; slave = sequencer, master = upstream source + directory
interface dir_request_sequencer_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [3:0] req_address_i;
  logic [1:0] req_op_i;
  logic [1:0] req_proc_i;
  logic [3:0] req_data_i;
  logic [3:0] address_test_o;
  logic [1:0] write_or_read_o;
  logic [1:0] processor_o;
  logic [3:0] data_test_o;
  logic       txn_done_i;
  logic       busy_o;
  logic [2:0] count_o;
  logic       bad_req_o;
  logic       timed_out_o;
  modport slave (
    input  req_valid_i, req_address_i, req_op_i, req_proc_i, req_data_i, txn_done_i,
    output req_ready_o, address_test_o, write_or_read_o, processor_o, data_test_o,
           busy_o, count_o, bad_req_o, timed_out_o
  );
  modport master (
    output req_valid_i, req_address_i, req_op_i, req_proc_i, req_data_i, txn_done_i,
    input  req_ready_o, address_test_o, write_or_read_o, processor_o, data_test_o,
           busy_o, count_o, bad_req_o, timed_out_o
  );
endinterface

// File: rtl/dir_request_sequencer.sv
// dir_request_sequencer: FIFO-buffered, one-at-a-time issuer of memory requests (clk, rst async high, bus = request/issue interface)
module dir_request_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  dir_request_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] FULL = 3'(DEPTH);
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
  logic [11:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;
  state_t        state_q;
  logic [3:0]    timer_q, addr_q, data_q;
  logic [1:0]    op_q, proc_q;
  logic          bad_q, timed_out_q;
  logic          legal, accept, push, pop;
  assign legal = (bus.req_address_i inside {[4'd1:4'd8]}) &&
                 (bus.req_op_i inside {2'b01, 2'b10}) &&
                 (bus.req_proc_i inside {2'b01, 2'b10});
  // Ready looks only at occupancy, so a full FIFO refuses even while popping
  assign bus.req_ready_o = count_q != FULL;
  assign accept = bus.req_valid_i && bus.req_ready_o;
  assign push = accept && legal;
  assign pop = state_q == IDLE && count_q != '0;
  assign count_d = count_q + 3'(push) - 3'(pop);
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {bus.req_address_i, bus.req_op_i, bus.req_proc_i,
                                  bus.req_op_i == 2'b10 ? bus.req_data_i : 4'd0};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_q  <= count_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      addr_q      <= '0;
      op_q        <= '0;
      proc_q      <= '0;
      data_q      <= '0;
      bad_q       <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      bad_q <= accept && !legal;
      case (state_q)
        IDLE: if (pop) begin
          {addr_q, op_q, proc_q, data_q} <= mem_q[rd_ptr_q];
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: if (bus.txn_done_i || timer_q == TO_LAST) begin
          // Done wins over a coincident timeout
          timed_out_q <= timed_out_q || !bus.txn_done_i;
          {addr_q, op_q, proc_q, data_q} <= '0;
          state_q <= GAP;
        end else timer_q <= timer_q + 4'd1;
        default: state_q <= IDLE;
      endcase
    end
  assign bus.address_test_o  = addr_q;
  assign bus.write_or_read_o = op_q;
  assign bus.processor_o     = proc_q;
  assign bus.data_test_o     = data_q;
  assign bus.busy_o          = state_q != IDLE || count_q != '0;
  assign bus.count_o         = count_q;
  assign bus.bad_req_o       = bad_q;
  assign bus.timed_out_o     = timed_out_q;
endmodule

// File: tb/tb_dir_request_sequencer.sv
// tb_dir_request_sequencer: directed scenario bench for dir_request_sequencer
module tb_dir_request_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  dir_request_sequencer_if bus_if();
  dir_request_sequencer #(.DEPTH(4), .TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus_if));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] a, input logic [1:0] op, input logic [1:0] p, input logic [3:0] d);
    bus_if.req_address_i = a;
    bus_if.req_op_i = op;
    bus_if.req_proc_i = p;
    bus_if.req_data_i = d;
    bus_if.req_valid_i = 1'b1;
    step();
    bus_if.req_valid_i = 1'b0;
  endtask
  function automatic logic [11:0] bus_vec();
    return {bus_if.address_test_o, bus_if.write_or_read_o, bus_if.processor_o, bus_if.data_test_o};
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++;
    if ({bus_vec(), bus_if.busy_o, bus_if.count_o, bus_if.bad_req_o, bus_if.timed_out_o} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h exp 0", {bus_vec(), bus_if.busy_o, bus_if.count_o, bus_if.bad_req_o, bus_if.timed_out_o});
    end
    tests++;
    if (bus_if.req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b exp 1", bus_if.req_ready_o);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_read();
    drive(4'b0001, 2'b01, 2'b01, 4'b1111);
    tests++;
    if (bus_if.count_o !== 3'd1 || bus_if.write_or_read_o !== 2'b00 || bus_if.busy_o !== 1'b1) begin
      fails++;
      $display("FAIL read_queued got count=%0d wor=%b busy=%b exp 1/00/1", bus_if.count_o, bus_if.write_or_read_o, bus_if.busy_o);
    end
    step();
    tests++;
    if (bus_vec() !== 12'b0001_01_01_0000 || bus_if.count_o !== 3'd0) begin
      fails++;
      $display("FAIL read_issue got %b count=%0d exp 000101010000 count=0", bus_vec(), bus_if.count_o);
    end
    bus_if.txn_done_i = 1'b1;
    step();
    bus_if.txn_done_i = 1'b0;
    tests++;
    if (bus_vec() !== 12'd0 || bus_if.busy_o !== 1'b1) begin
      fails++;
      $display("FAIL read_gap got %b busy=%b exp 0 busy=1", bus_vec(), bus_if.busy_o);
    end
    step();
    tests++;
    if (bus_vec() !== 12'd0 || bus_if.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL read_idle got %b busy=%b exp 0 busy=0", bus_vec(), bus_if.busy_o);
    end
  endtask
  task automatic test_bad();
    logic [9:0] vecs [4];
    vecs[0] = {4'b0000, 2'b01, 2'b01, 2'b00};
    vecs[1] = {4'b0010, 2'b11, 2'b01, 2'b00};
    vecs[2] = {4'b0010, 2'b10, 2'b00, 2'b00};
    vecs[3] = {4'b1001, 2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i][9:6], vecs[i][5:4], vecs[i][3:2], 4'b0101);
      tests++;
      if (bus_if.bad_req_o !== 1'b1 || bus_if.count_o !== 3'd0) begin
        fails++;
        $display("FAIL bad_pulse[%0d] got bad=%b count=%0d exp 1/0", i, bus_if.bad_req_o, bus_if.count_o);
      end
      step();
      tests++;
      if (bus_if.bad_req_o !== 1'b0 || bus_vec() !== 12'd0 || bus_if.busy_o !== 1'b0) begin
        fails++;
        $display("FAIL bad_after[%0d] got bad=%b bus=%b busy=%b exp 0/0/0", i, bus_if.bad_req_o, bus_vec(), bus_if.busy_o);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [11:0] exp [5];
    int bound;
    for (int k = 0; k < 5; k++) begin
      exp[k] = {4'(k + 1), (k % 2) ? 2'b10 : 2'b01, (k % 2) ? 2'b01 : 2'b10, (k % 2) ? 4'(k + 2) : 4'd0};
      bound = 0;
      while (!bus_if.req_ready_o && bound < 50) begin
        step();
        bound++;
      end
      tests++;
      if (bound >= 50) begin
        fails++;
        $display("FAIL b2b_ready_timeout[%0d] got ready=0 exp 1", k);
      end
      drive(4'(k + 1), (k % 2) ? 2'b10 : 2'b01, (k % 2) ? 2'b01 : 2'b10, 4'(k + 2));
    end
    tests++;
    if (bus_if.count_o !== 3'd4 || bus_if.req_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL b2b_full got count=%0d ready=%b exp 4/0", bus_if.count_o, bus_if.req_ready_o);
    end
    drive(4'b1000, 2'b01, 2'b01, 4'd0);
    tests++;
    if (bus_if.count_o !== 3'd4) begin
      fails++;
      $display("FAIL b2b_refuse got count=%0d exp 4", bus_if.count_o);
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (bus_vec() !== exp[k]) begin
        fails++;
        $display("FAIL b2b_order[%0d] got %b exp %b", k, bus_vec(), exp[k]);
      end
      bus_if.txn_done_i = 1'b1;
      step();
      bus_if.txn_done_i = 1'b0;
      step();
      step();
    end
    tests++;
    if (bus_if.busy_o !== 1'b0 || bus_if.count_o !== 3'd0 || bus_if.timed_out_o !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drained got busy=%b count=%0d to=%b exp 0/0/0", bus_if.busy_o, bus_if.count_o, bus_if.timed_out_o);
    end
  endtask
  task automatic test_gap_ignore();
    drive(4'b0100, 2'b10, 2'b01, 4'b1001);
    drive(4'b0100, 2'b10, 2'b01, 4'b1001);
    bus_if.txn_done_i = 1'b1;
    step();
    tests++;
    if (bus_if.write_or_read_o !== 2'b00) begin
      fails++;
      $display("FAIL gap_zero got wor=%b exp 00", bus_if.write_or_read_o);
    end
    step();
    bus_if.txn_done_i = 1'b0;
    step();
    tests++;
    if (bus_vec() !== 12'b0100_10_01_1001) begin
      fails++;
      $display("FAIL gap_second_issue got %b exp 010010011001", bus_vec());
    end
    step();
    step();
    step();
    tests++;
    if (bus_vec() !== 12'b0100_10_01_1001) begin
      fails++;
      $display("FAIL gap_second_held got %b exp 010010011001", bus_vec());
    end
    bus_if.txn_done_i = 1'b1;
    step();
    bus_if.txn_done_i = 1'b0;
    step();
    tests++;
    if (bus_if.busy_o !== 1'b0 || bus_vec() !== 12'd0) begin
      fails++;
      $display("FAIL gap_done got busy=%b bus=%b exp 0/0", bus_if.busy_o, bus_vec());
    end
  endtask
  task automatic test_timeout();
    drive(4'b0011, 2'b10, 2'b10, 4'b0110);
    drive(4'b0101, 2'b01, 2'b01, 4'b1111);
    for (int i = 0; i < 14; i++) step();
    tests++;
    if (bus_vec() !== 12'b0011_10_10_0110 || bus_if.timed_out_o !== 1'b0) begin
      fails++;
      $display("FAIL to_hold got %b to=%b exp 001110100110 to=0", bus_vec(), bus_if.timed_out_o);
    end
    step();
    tests++;
    if (bus_vec() !== 12'd0 || bus_if.timed_out_o !== 1'b1) begin
      fails++;
      $display("FAIL to_fire got %b to=%b exp 0 to=1", bus_vec(), bus_if.timed_out_o);
    end
    step();
    step();
    tests++;
    if (bus_vec() !== 12'b0101_01_01_0000 || bus_if.timed_out_o !== 1'b1) begin
      fails++;
      $display("FAIL to_next got %b to=%b exp 010101010000 to=1", bus_vec(), bus_if.timed_out_o);
    end
    bus_if.txn_done_i = 1'b1;
    step();
    bus_if.txn_done_i = 1'b0;
    step();
  endtask
  task automatic test_reset_mid_wait();
    for (int k = 0; k < 4; k++) drive(4'(k + 1), 2'b01, 2'b01, 4'd0);
    tests++;
    if (bus_if.count_o !== 3'd3 || bus_if.write_or_read_o !== 2'b01) begin
      fails++;
      $display("FAIL rst_pre got count=%0d wor=%b exp 3/01", bus_if.count_o, bus_if.write_or_read_o);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({bus_vec(), bus_if.count_o, bus_if.timed_out_o, bus_if.busy_o} !== 17'd0) begin
      fails++;
      $display("FAIL rst_async got %h exp 0", {bus_vec(), bus_if.count_o, bus_if.timed_out_o, bus_if.busy_o});
    end
    #1 rst = 1'b0;
    step();
    step();
    tests++;
    if (bus_vec() !== 12'd0 || bus_if.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_discard got %b busy=%b exp 0/0", bus_vec(), bus_if.busy_o);
    end
  endtask
  task automatic test_coincident_done();
    drive(4'b0110, 2'b01, 2'b10, 4'd0);
    step();
    for (int i = 0; i < 14; i++) step();
    bus_if.txn_done_i = 1'b1;
    step();
    bus_if.txn_done_i = 1'b0;
    tests++;
    if (bus_if.timed_out_o !== 1'b0 || bus_vec() !== 12'd0) begin
      fails++;
      $display("FAIL coincident got to=%b bus=%b exp 0/0", bus_if.timed_out_o, bus_vec());
    end
    step();
    step();
    tests++;
    if (bus_if.timed_out_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL coincident_after got to=%b busy=%b exp 0/0", bus_if.timed_out_o, bus_if.busy_o);
    end
  endtask
  initial begin
    bus_if.req_valid_i = 1'b0;
    bus_if.req_address_i = '0;
    bus_if.req_op_i = '0;
    bus_if.req_proc_i = '0;
    bus_if.req_data_i = '0;
    bus_if.txn_done_i = 1'b0;
    test_reset();
    test_read();
    test_bad();
    test_back_to_back();
    test_gap_ignore();
    test_timeout();
    test_reset_mid_wait();
    test_coincident_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
